// File: rtl/riscv_core_dcache_axi_bridge.sv
// Data-cache to AXI bridge: single-beat block refills and doubleword write-throughs.
// Every AXI-facing output is driven straight from a flop.
module riscv_core_dcache_axi_bridge #(
  parameter int ADDR_WIDTH      = 64,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH  = 256
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]         i_mem_read_address,
  output logic                          o_mem_read_done,
  output logic [AXI_DATA_WIDTH-1:0]     o_mem_read_data,
  input  logic                          i_mem_write_valid,
  input  logic [CORE_DATA_WIDTH-1:0]    i_mem_write_data,
  input  logic [ADDR_WIDTH-1:0]         i_mem_write_address,
  input  logic [CORE_DATA_WIDTH/8-1:0]  i_mem_write_strobe,
  output logic                          o_mem_write_done,
  output logic                          o_mem_err,
  output logic                          o_axi_arvalid,
  input  logic                          i_axi_arready,
  output logic [ADDR_WIDTH-1:0]         o_axi_araddr,
  output logic [7:0]                    o_axi_arlen,
  output logic [2:0]                    o_axi_arsize,
  output logic [1:0]                    o_axi_arburst,
  input  logic                          i_axi_rvalid,
  output logic                          o_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]     i_axi_rdata,
  input  logic [1:0]                    i_axi_rresp,
  output logic                          o_axi_awvalid,
  input  logic                          i_axi_awready,
  output logic [ADDR_WIDTH-1:0]         o_axi_awaddr,
  output logic [7:0]                    o_axi_awlen,
  output logic [2:0]                    o_axi_awsize,
  output logic [1:0]                    o_axi_awburst,
  output logic                          o_axi_wvalid,
  input  logic                          i_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]     o_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_axi_wstrb,
  output logic                          o_axi_wlast,
  input  logic                          i_axi_bvalid,
  output logic                          o_axi_bready,
  input  logic [1:0]                    i_axi_bresp
);

  localparam int AXI_STRB_W  = AXI_DATA_WIDTH / 8;
  localparam int CORE_STRB_W = CORE_DATA_WIDTH / 8;
  localparam int OFF_BITS    = $clog2(AXI_STRB_W);
  localparam int LANES       = AXI_DATA_WIDTH / CORE_DATA_WIDTH;
  localparam int LANE_BITS   = $clog2(LANES);
  localparam logic [2:0] AXI_SIZE = 3'(OFF_BITS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t state, state_next;

  logic                 rd_accept, wr_accept, aw_ok, w_ok;
  logic [LANE_BITS-1:0] wr_lane;
  logic                 unused_bits;

  // The done pulses block acceptance, which enforces the idle cycle between transactions.
  assign rd_accept = (state == IDLE) && !o_mem_read_done && !o_mem_write_done && i_mem_read_req;
  assign wr_accept = (state == IDLE) && !o_mem_read_done && !o_mem_write_done &&
                     !i_mem_read_req && i_mem_write_valid;
  assign aw_ok     = !o_axi_awvalid || i_axi_awready;
  assign w_ok      = !o_axi_wvalid || i_axi_wready;
  assign wr_lane   = i_mem_write_address[OFF_BITS-1 -: LANE_BITS];

  assign unused_bits = ^{i_mem_read_address[OFF_BITS-1:0],
                         i_mem_write_address[OFF_BITS-LANE_BITS-1:0],
                         i_axi_rresp[0], i_axi_bresp[0]};

  assign o_axi_arlen   = 8'd0;
  assign o_axi_arsize  = AXI_SIZE;
  assign o_axi_arburst = 2'b01;
  assign o_axi_awlen   = 8'd0;
  assign o_axi_awsize  = AXI_SIZE;
  assign o_axi_awburst = 2'b01;
  assign o_axi_wlast   = 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rd_accept)      state_next = RD_ADDR;
        else if (wr_accept) state_next = WR_REQ;
      end
      RD_ADDR: if (i_axi_arready)  state_next = RD_DATA;
      RD_DATA: if (i_axi_rvalid)   state_next = IDLE;
      WR_REQ:  if (aw_ok && w_ok)  state_next = WR_RESP;
      WR_RESP: if (i_axi_bvalid)   state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_axi_arvalid    <= 1'b0;
      o_axi_araddr     <= '0;
      o_axi_rready     <= 1'b0;
      o_axi_awvalid    <= 1'b0;
      o_axi_awaddr     <= '0;
      o_axi_wvalid     <= 1'b0;
      o_axi_wdata      <= '0;
      o_axi_wstrb      <= '0;
      o_axi_bready     <= 1'b0;
      o_mem_read_done  <= 1'b0;
      o_mem_read_data  <= '0;
      o_mem_write_done <= 1'b0;
      o_mem_err        <= 1'b0;
    end else begin
      o_mem_read_done  <= 1'b0;
      o_mem_write_done <= 1'b0;
      o_mem_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_accept) begin
            o_axi_araddr  <= {i_mem_read_address[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            o_axi_arvalid <= 1'b1;
          end else if (wr_accept) begin
            o_axi_awaddr  <= {i_mem_write_address[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            o_axi_wdata   <= {LANES{i_mem_write_data}};
            o_axi_wstrb   <= AXI_STRB_W'(i_mem_write_strobe) << (wr_lane * CORE_STRB_W);
            o_axi_awvalid <= 1'b1;
            o_axi_wvalid  <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (i_axi_arready) begin
            o_axi_arvalid <= 1'b0;
            o_axi_rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (i_axi_rvalid) begin
            o_axi_rready    <= 1'b0;
            o_mem_read_data <= i_axi_rdata;
            o_mem_read_done <= 1'b1;
            o_mem_err       <= i_axi_rresp[1];
          end
        end
        WR_REQ: begin
          // AW and W retire independently; B is only opened once both have gone.
          if (i_axi_awready) o_axi_awvalid <= 1'b0;
          if (i_axi_wready)  o_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) o_axi_bready  <= 1'b1;
        end
        WR_RESP: begin
          if (i_axi_bvalid) begin
            o_axi_bready     <= 1'b0;
            o_mem_write_done <= 1'b1;
            o_mem_err        <= i_axi_bresp[1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_dcache_axi_bridge.sv
// Directed bench for the dcache AXI bridge: refill, store, skew, errors, contention, stall, reset.
module tb_riscv_core_dcache_axi_bridge;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_mem_read_req = 1'b0;
  logic [63:0]  i_mem_read_address = '0;
  logic         o_mem_read_done;
  logic [255:0] o_mem_read_data;
  logic         i_mem_write_valid = 1'b0;
  logic [63:0]  i_mem_write_data = '0;
  logic [63:0]  i_mem_write_address = '0;
  logic [7:0]   i_mem_write_strobe = '0;
  logic         o_mem_write_done;
  logic         o_mem_err;
  logic         o_axi_arvalid;
  logic         i_axi_arready = 1'b0;
  logic [63:0]  o_axi_araddr;
  logic [7:0]   o_axi_arlen;
  logic [2:0]   o_axi_arsize;
  logic [1:0]   o_axi_arburst;
  logic         i_axi_rvalid = 1'b0;
  logic         o_axi_rready;
  logic [255:0] i_axi_rdata = '0;
  logic [1:0]   i_axi_rresp = '0;
  logic         o_axi_awvalid;
  logic         i_axi_awready = 1'b0;
  logic [63:0]  o_axi_awaddr;
  logic [7:0]   o_axi_awlen;
  logic [2:0]   o_axi_awsize;
  logic [1:0]   o_axi_awburst;
  logic         o_axi_wvalid;
  logic         i_axi_wready = 1'b0;
  logic [255:0] o_axi_wdata;
  logic [31:0]  o_axi_wstrb;
  logic         o_axi_wlast;
  logic         i_axi_bvalid = 1'b0;
  logic         o_axi_bready;
  logic [1:0]   i_axi_bresp = '0;

  int n_checks = 0;
  int n_errors = 0;

  riscv_core_dcache_axi_bridge dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mem_read_req(i_mem_read_req), .i_mem_read_address(i_mem_read_address),
    .o_mem_read_done(o_mem_read_done), .o_mem_read_data(o_mem_read_data),
    .i_mem_write_valid(i_mem_write_valid), .i_mem_write_data(i_mem_write_data),
    .i_mem_write_address(i_mem_write_address), .i_mem_write_strobe(i_mem_write_strobe),
    .o_mem_write_done(o_mem_write_done), .o_mem_err(o_mem_err),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready), .o_axi_araddr(o_axi_araddr),
    .o_axi_arlen(o_axi_arlen), .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
    .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready), .i_axi_rdata(i_axi_rdata),
    .i_axi_rresp(i_axi_rresp),
    .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready), .o_axi_awaddr(o_axi_awaddr),
    .o_axi_awlen(o_axi_awlen), .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready), .o_axi_wdata(o_axi_wdata),
    .o_axi_wstrb(o_axi_wstrb), .o_axi_wlast(o_axi_wlast),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready), .i_axi_bresp(i_axi_bresp)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, 256'({o_axi_arvalid, o_axi_rready, o_axi_awvalid, o_axi_wvalid,
                              o_axi_bready, o_mem_read_done, o_mem_write_done, o_mem_err}), 256'd0);
    check({tag, " rdata"}, o_mem_read_data, 256'd0);
    check({tag, " addr"}, 256'({o_axi_araddr, o_axi_awaddr}), 256'd0);
    check({tag, " wdata"}, o_axi_wdata, 256'd0);
    check({tag, " wstrb"}, 256'(o_axi_wstrb), 256'd0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    check("tie arsize", 256'(o_axi_arsize), 256'd5);
    check("tie wlast", 256'(o_axi_wlast), 256'd1);
    step();
    i_rst = 1'b0;
    step();

    // Refill
    i_mem_read_req = 1'b1;
    i_mem_read_address = 64'h1234_5678;
    step();
    i_mem_read_address = 64'hFFFF_FFFF_FFFF_FFFF;
    check("rd arvalid", 256'(o_axi_arvalid), 256'd1);
    check("rd araddr", 256'(o_axi_araddr), 256'h1234_5660);
    check("rd arlen", 256'(o_axi_arlen), 256'd0);
    i_axi_arready = 1'b1;
    step();
    check("rd arvalid drop", 256'(o_axi_arvalid), 256'd0);
    check("rd rready", 256'(o_axi_rready), 256'd1);
    check("rd done early", 256'(o_mem_read_done), 256'd0);
    i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b1;
    i_axi_rdata = {32{8'hA5}};
    i_axi_rresp = 2'b00;
    step();
    check("rd done", 256'(o_mem_read_done), 256'd1);
    check("rd err", 256'(o_mem_err), 256'd0);
    check("rd data", o_mem_read_data, {32{8'hA5}});
    check("rd rready drop", 256'(o_axi_rready), 256'd0);
    i_mem_read_req = 1'b0;
    i_axi_rvalid = 1'b0;
    i_axi_rdata = '0;
    step();
    check("rd done pulse", 256'(o_mem_read_done), 256'd0);
    check("rd data held", o_mem_read_data, {32{8'hA5}});

    // Store
    i_mem_write_valid = 1'b1;
    i_mem_write_address = 64'h1010;
    i_mem_write_strobe = 8'h0F;
    i_mem_write_data = 64'h1122_3344_5566_7788;
    step();
    i_mem_write_data = '0;
    i_mem_write_strobe = 8'hFF;
    i_mem_write_address = 64'h18;
    check("wr aw/w valid", 256'({o_axi_awvalid, o_axi_wvalid}), 256'b11);
    check("wr awaddr", 256'(o_axi_awaddr), 256'h1000);
    check("wr wstrb", 256'(o_axi_wstrb), 256'h000F_0000);
    check("wr wdata", o_axi_wdata, {4{64'h1122_3344_5566_7788}});
    check("wr bready early", 256'(o_axi_bready), 256'd0);
    i_axi_awready = 1'b1;
    i_axi_wready = 1'b1;
    step();
    check("wr valids drop", 256'({o_axi_awvalid, o_axi_wvalid}), 256'b00);
    check("wr bready", 256'(o_axi_bready), 256'd1);
    i_axi_awready = 1'b0;
    i_axi_wready = 1'b0;
    i_axi_bvalid = 1'b1;
    i_axi_bresp = 2'b00;
    step();
    check("wr done", 256'(o_mem_write_done), 256'd1);
    check("wr err", 256'(o_mem_err), 256'd0);
    i_mem_write_valid = 1'b0;
    i_axi_bvalid = 1'b0;
    step();
    check("wr done pulse", 256'(o_mem_write_done), 256'd0);

    // AW/W skew plus bresp DECERR; wdata DEADBEEF in lane 3
    i_mem_write_valid = 1'b1;
    i_mem_write_address = 64'h18;
    i_mem_write_strobe = 8'hFF;
    i_mem_write_data = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    check("skew wstrb", 256'(o_axi_wstrb), 256'hFF00_0000);
    check("skew awaddr", 256'(o_axi_awaddr), 256'h0);
    i_axi_wready = 1'b1;
    step();
    i_axi_wready = 1'b0;
    check("skew wvalid drop", 256'(o_axi_wvalid), 256'd0);
    for (int i = 0; i < 2; i++) begin
      check("skew awvalid held", 256'(o_axi_awvalid), 256'd1);
      check("skew bready wait", 256'(o_axi_bready), 256'd0);
      step();
    end
    check("skew awvalid held", 256'(o_axi_awvalid), 256'd1);
    i_axi_awready = 1'b1;
    step();
    i_axi_awready = 1'b0;
    check("skew awvalid drop", 256'(o_axi_awvalid), 256'd0);
    check("skew bready", 256'(o_axi_bready), 256'd1);
    i_axi_bvalid = 1'b1;
    i_axi_bresp = 2'b11;
    step();
    check("werr done", 256'(o_mem_write_done), 256'd1);
    check("werr err", 256'(o_mem_err), 256'd1);
    i_mem_write_valid = 1'b0;
    i_axi_bvalid = 1'b0;
    i_axi_bresp = 2'b00;
    step();
    check("werr single done", 256'({o_mem_write_done, o_mem_err}), 256'd0);
    step();
    check("werr no extra done", 256'(o_mem_write_done), 256'd0);

    // Read SLVERR with immediate ready/valid: done three cycles after accept
    i_axi_arready = 1'b1;
    i_axi_rvalid = 1'b1;
    i_axi_rresp = 2'b10;
    i_axi_rdata = {8{32'hCAFE_0001}};
    i_mem_read_req = 1'b1;
    i_mem_read_address = 64'h40;
    step();
    check("rerr araddr", 256'(o_axi_araddr), 256'h40);
    step();
    check("rerr not done yet", 256'(o_mem_read_done), 256'd0);
    step();
    check("rerr done+err", 256'({o_mem_read_done, o_mem_err}), 256'b11);
    check("rerr data", o_mem_read_data, {8{32'hCAFE_0001}});
    i_mem_read_req = 1'b0;
    i_axi_rresp = 2'b00;
    step();

    // Contention: read wins, write waits then issues after the idle gap
    i_mem_read_req = 1'b1;
    i_mem_read_address = 64'h2000;
    i_mem_write_valid = 1'b1;
    i_mem_write_address = 64'h3008;
    i_mem_write_strobe = 8'h01;
    i_mem_write_data = 64'h55;
    step();
    check("cont ar first", 256'({o_axi_arvalid, o_axi_awvalid}), 256'b10);
    step();
    step();
    check("cont rd done", 256'(o_mem_read_done), 256'd1);
    check("cont no aw", 256'(o_axi_awvalid), 256'd0);
    i_mem_read_req = 1'b0;
    step();
    check("cont gap", 256'(o_axi_awvalid), 256'd0);
    step();
    check("cont aw after", 256'(o_axi_awvalid), 256'd1);
    check("cont awaddr", 256'(o_axi_awaddr), 256'h3000);
    check("cont wstrb", 256'(o_axi_wstrb), 256'h0000_0100);
    i_axi_awready = 1'b1;
    i_axi_wready = 1'b1;
    i_axi_bvalid = 1'b1;
    step();
    step();
    check("cont wr done", 256'(o_mem_write_done), 256'd1);
    i_mem_write_valid = 1'b0;
    i_axi_awready = 1'b0;
    i_axi_wready = 1'b0;
    i_axi_bvalid = 1'b0;
    i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b0;
    step();

    // AR stall: arready low for 10 cycles
    i_mem_read_req = 1'b1;
    i_mem_read_address = 64'hABCD_EF3F;
    step();
    i_mem_read_address = 64'h0;
    for (int i = 0; i < 10; i++) begin
      check("stall araddr", 256'({o_axi_arvalid, o_axi_araddr}), {191'd0, 1'b1, 64'hABCD_EF20});
      step();
    end
    i_axi_arready = 1'b1;
    step();
    i_axi_arready = 1'b0;
    check("stall ar done", 256'({o_axi_arvalid, o_axi_rready}), 256'b01);

    // Reset in RD_DATA, then a fresh read
    i_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    i_rst = 1'b0;
    i_mem_read_address = 64'h80;
    i_axi_arready = 1'b1;
    i_axi_rvalid = 1'b1;
    i_axi_rdata = {16{16'h5A3C}};
    step();
    check("post rst arvalid", 256'(o_axi_arvalid), 256'd1);
    step();
    step();
    check("post rst done", 256'({o_mem_read_done, o_mem_err}), 256'b10);
    check("post rst data", o_mem_read_data, {16{16'h5A3C}});
    i_mem_read_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_core_dcache_axi_bridge.md
RISCV_CORE_DCACHE_AXI_BRIDGE -- requirements
Module: riscv_core_dcache_axi_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, byte address width on both sides.
REQ-002 Parameter CORE_DATA_WIDTH, default 64, width of the core-side write data.
REQ-003 Parameter AXI_DATA_WIDTH, default 256, AXI data width; also the cache block size (32 bytes).
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  reset; asynchronous, active-high.
REQ-006 i_mem_read_req  in  1  block refill request from the cache controller, held high until o_mem_read_done.
REQ-007 i_mem_read_address  in  ADDR_WIDTH  block-aligned refill address.
REQ-008 o_mem_read_done  out  1  one-cycle refill-complete pulse.
REQ-009 o_mem_read_data  out  AXI_DATA_WIDTH  refilled block; valid when o_mem_read_done is high.
REQ-010 i_mem_write_valid  in  1  write-through request, held high until o_mem_write_done.
REQ-011 i_mem_write_data  in  CORE_DATA_WIDTH  write-through data (doubleword lane).
REQ-012 i_mem_write_address  in  ADDR_WIDTH  byte address of the store.
REQ-013 i_mem_write_strobe  in  8  byte enables within the doubleword.
REQ-014 o_mem_write_done  out  1  one-cycle write-complete pulse.
REQ-015 o_mem_err  out  1  pulses with either done when the AXI response is SLVERR or DECERR.
REQ-016 o_axi_arvalid, i_axi_arready, o_axi_araddr (ADDR_WIDTH): AXI AR channel.
REQ-017 i_axi_rvalid, o_axi_rready, i_axi_rdata (AXI_DATA_WIDTH), i_axi_rresp (2): AXI R channel.
REQ-018 o_axi_awvalid, i_axi_awready, o_axi_awaddr (ADDR_WIDTH): AXI AW channel.
REQ-019 o_axi_wvalid, i_axi_wready, o_axi_wdata (AXI_DATA_WIDTH), o_axi_wstrb (AXI_DATA_WIDTH/8): AXI W channel.
REQ-020 i_axi_bvalid, o_axi_bready, i_axi_bresp (2): AXI B channel.
REQ-021 All transfers shall be single-beat INCR at full bus width, ID 0; the top level ties LEN=0, SIZE=5, BURST=INCR, WLAST=1.

Function
REQ-022 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-023 Requests shall be sampled only in IDLE, and only while both done outputs are low.
REQ-024 If read and write requests are both present in IDLE, the read shall win; the write shall wait, still held.
REQ-025 On read accept: o_axi_araddr <= {addr[63:5], 5'b0}; arvalid=1 next cycle; go to RD_ADDR.
REQ-026 RD_ADDR: arvalid held with araddr stable until arready is high; then arvalid=0 and go to RD_DATA.
REQ-027 RD_DATA: rready=1; on rvalid, capture rdata into o_mem_read_data and go to IDLE with o_mem_read_done=1 for exactly one cycle.
REQ-028 o_mem_read_data shall hold its value until the next R handshake.
REQ-029 On write accept: register the following, then assert awvalid and wvalid together next cycle and go to WR_REQ:
- awaddr = {addr[63:5], 5'b0};
- wdata = data replicated 4x;
- wstrb = strobe << (8*addr[4:3]).
REQ-030 WR_REQ: awvalid and wvalid shall each deassert independently after their own handshake, in either order or the same cycle; once both are complete, go to WR_RESP.
REQ-031 WR_RESP: bready=1; on bvalid, go to IDLE with o_mem_write_done=1 for one cycle.
REQ-032 o_mem_err = done pulse AND resp[1] of that transaction; done shall still be issued on error.
REQ-033 AXI outputs come from registers only, with no combinational path from any input to any output.
REQ-034 Registered address, data and strobe shall be immune to core-side input changes after accept.
REQ-035 Back-to-back requests: the minimum gap is one idle cycle after a done pulse.
REQ-036 Latency with immediate ready/valid: read done 3 cycles after accept; write done 3 cycles after accept.

Reset
REQ-037 While i_rst is high, asynchronously and regardless of any in-flight transaction:
- state = IDLE;
- all valid, ready, done and err outputs = 0;
- o_mem_read_data, addresses, wdata and wstrb = 0.
REQ-038 Operation shall resume in the first cycle after i_rst deasserts.

Verification
REQ-039 Refill: req with addr 0x1234_5678 -> araddr 0x1234_5660; rdata 0xA5..A5 OKAY -> one-cycle done, data 0xA5..A5 held afterward.
REQ-040 Store: addr 0x1010 (addr[4:3]=2), strobe 0x0F, data 0x1122334455667788 -> awaddr 0x1000, wstrb 0x000F_0000, wdata replicated 4x; done after bresp.
REQ-041 AW/W skew: awready 3 cycles after wready -> wvalid drops first, awvalid held; bready only after both complete; a single done.
REQ-042 Error: rresp=2'b10 -> o_mem_read_done and o_mem_err high the same cycle; bresp=2'b11 -> write done plus err.
REQ-043 Contention and stall: read and write requested together -> AR issued first, write served afterward. Separately, arready held low 10 cycles -> araddr stable the whole time.
REQ-044 Reset mid-RD_DATA -> all outputs 0 immediately; after release a fresh read completes normally.
